// File: rtl/bullet_if.sv
`timescale 1ns/1ps
// Bus between the player-bullet engine and the rest of the game.
// Inputs carry positions, tick and fire; outputs carry bullet state and the alien map.
interface bullet_if;
  logic        tick;
  logic        fire;
  logic [8:0]  player_row;
  logic [9:0]  player_col;
  logic [8:0]  aliens_row;
  logic [9:0]  aliens_col;
  logic [8:0]  bullet_row;
  logic [9:0]  bullet_col;
  logic        bullet_exists;
  logic [49:0] aliens_grid;
  logic        hit_pulse;
  logic        aliens_defeated;
  logic [7:0]  score;

  modport master (
    output tick, fire, player_row, player_col, aliens_row, aliens_col,
    input  bullet_row, bullet_col, bullet_exists, aliens_grid, hit_pulse,
           aliens_defeated, score
  );

  modport slave (
    input  tick, fire, player_row, player_col, aliens_row, aliens_col,
    output bullet_row, bullet_col, bullet_exists, aliens_grid, hit_pulse,
           aliens_defeated, score
  );
endinterface

// File: rtl/bullet_ctrl.sv
`timescale 1ns/1ps
// Player-bullet engine: launch on fire edge, climb per tick, hit-test against the 5x10 formation.
// Optional macro BULLET_SCORE_EN enables the saturating hit counter on score.
module bullet_ctrl (
  input  logic     board_clk,
  input  logic     reset,
  bullet_if.slave  bus
);
  localparam int unsigned GRID_COLS   = 10;
  localparam int unsigned GRID_ROWS   = 5;
  localparam int unsigned CELL_W_LG2  = 5;
  localparam int unsigned CELL_H_LG2  = 5;
  localparam int unsigned SPRITE_W    = 24;
  localparam int unsigned SPRITE_H    = 24;
  localparam int unsigned PLAYER_W    = 32;
  localparam int unsigned BULLET_LEN  = 8;
  localparam int unsigned BULLET_STEP = 4;
  localparam int unsigned N_ALIENS    = GRID_COLS * GRID_ROWS;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned ROW_W       = 9;
  localparam int unsigned COL_W       = 10;
  localparam int unsigned DIFF_W      = 11;

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_CHECK, S_HIT} state_t;

  state_t              r_state;
  logic                r_fire_s1;
  logic                r_fire_s2;
  logic                r_fire_d;
  logic                r_fire_rise;
  logic [ROW_W-1:0]    r_bullet_row;
  logic [COL_W-1:0]    r_bullet_col;
  logic                r_bullet_exists;
  logic [N_ALIENS-1:0] r_grid;
  logic                r_hit_pulse;
  logic                r_defeated;
  logic [IDX_W-1:0]    r_idx;

  logic [DIFF_W-1:0]   w_dx;
  logic [DIFF_W-1:0]   w_dy;
  logic                w_inside;
  logic [IDX_W-1:0]    w_idx;
  logic                w_hit;
  logic [ROW_W-1:0]    w_launch_row;
  logic [COL_W-1:0]    w_launch_col;

  // Bit DIFF_W-1 of each difference is the borrow: bullet left of / above the formation.
  assign w_dx = {1'b0, r_bullet_col} - {1'b0, bus.aliens_col};
  assign w_dy = {2'b0, r_bullet_row} - {2'b0, bus.aliens_row};

  assign w_inside = !w_dx[DIFF_W-1] && !w_dy[DIFF_W-1]
                 && (w_dx < DIFF_W'(GRID_COLS << CELL_W_LG2))
                 && (w_dy < DIFF_W'(GRID_ROWS << CELL_H_LG2))
                 && (w_dx[CELL_W_LG2-1:0] < CELL_W_LG2'(SPRITE_W))
                 && (w_dy[CELL_H_LG2-1:0] < CELL_H_LG2'(SPRITE_H));

  assign w_idx = IDX_W'(w_dy >> CELL_H_LG2) * IDX_W'(GRID_COLS) + IDX_W'(w_dx >> CELL_W_LG2);
  assign w_hit = w_inside && r_grid[w_idx];

  assign w_launch_row = (bus.player_row < ROW_W'(BULLET_LEN)) ? '0
                      : bus.player_row - ROW_W'(BULLET_LEN);
  assign w_launch_col = bus.player_col + COL_W'(PLAYER_W / 2);

  // Fire synchroniser, edge detector and bullet FSM with registered outputs.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_fire_s1       <= 1'b0;
      r_fire_s2       <= 1'b0;
      r_fire_d        <= 1'b0;
      r_fire_rise     <= 1'b0;
      r_bullet_row    <= '0;
      r_bullet_col    <= '0;
      r_bullet_exists <= 1'b0;
      r_grid          <= '1;
      r_hit_pulse     <= 1'b0;
      r_defeated      <= 1'b0;
      r_idx           <= '0;
    end else begin
      r_fire_s1   <= bus.fire;
      r_fire_s2   <= r_fire_s1;
      r_fire_d    <= r_fire_s2;
      r_fire_rise <= r_fire_s2 & ~r_fire_d;
      r_hit_pulse <= 1'b0;
      r_defeated  <= (r_grid == '0);
      case (r_state)
        S_IDLE: begin
          if (r_fire_rise) begin
            r_bullet_row    <= w_launch_row;
            r_bullet_col    <= w_launch_col;
            r_bullet_exists <= 1'b1;
            r_state         <= S_FLY;
          end
        end
        S_FLY: begin
          if (bus.tick) begin
            if (r_bullet_row < ROW_W'(BULLET_STEP)) begin
              r_bullet_exists <= 1'b0;
              r_state         <= S_IDLE;
            end else begin
              r_bullet_row <= r_bullet_row - ROW_W'(BULLET_STEP);
              r_state      <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          r_idx   <= w_idx;
          r_state <= w_hit ? S_HIT : S_FLY;
        end
        S_HIT: begin
          r_grid[r_idx]   <= 1'b0;
          r_bullet_exists <= 1'b0;
          r_hit_pulse     <= 1'b1;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BULLET_SCORE_EN
  logic [7:0] r_score;

  // Saturating hit counter.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_score <= '0;
    end else if (r_hit_pulse && (r_score != 8'hFF)) begin
      r_score <= r_score + 8'd1;
    end
  end

  assign bus.score = r_score;
`else
  assign bus.score = 8'h00;
`endif

  assign bus.bullet_row      = r_bullet_row;
  assign bus.bullet_col      = r_bullet_col;
  assign bus.bullet_exists   = r_bullet_exists;
  assign bus.aliens_grid     = r_grid;
  assign bus.hit_pulse       = r_hit_pulse;
  assign bus.aliens_defeated = r_defeated;
endmodule
